// File: rtl/sp_ram_arb_pkg.sv
// Shared constants and helpers for the single-port RAM arbiter.
// The SP_RAM_ARB_FIXED_PRIO_EN build option is consumed by rr_arbiter.
package sp_ram_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic RDWEN_WR = 1'b1;
    localparam logic RDWEN_RD = 1'b0;

    // Encoder for a one-hot (or zero) vector; zero input yields index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant with a registered rotation pointer.
// `define SP_RAM_ARB_FIXED_PRIO_EN gives index 0 absolute priority over the rest.
module rr_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    localparam logic [PW-1:0] RST_PTR = PW'(1);
`else
    localparam logic [PW-1:0] RST_PTR = '0;
`endif

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [MAX_REQ-1:0] gnt_ext;
    logic [IDX_W-1:0]   gnt_idx;

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            gnt[0] = 1'b1;
            found  = 1'b1;
        end
        // Rotation covers 1..N-1 only; index 0 never enters the ring.
        for (int i = 0; i < N - 1; i++) begin
            idx = PW'(1 + (32'(ptr_q) - 1 + i) % (N - 1));
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            idx = PW'((32'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        gnt_ext        = '0;
        gnt_ext[N-1:0] = gnt;
        gnt_idx        = onehot_to_idx(gnt_ext);
        ptr_d          = ptr_q;
        if (advance) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
            if (gnt_idx != '0) begin
                ptr_d = (32'(gnt_idx) == N - 1) ? PW'(1) : PW'(32'(gnt_idx) + 1);
            end
`else
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : PW'(32'(gnt_idx) + 1);
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) ptr_q <= RST_PTR;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM macro among NUM_REQ requesters, one access per cycle.
// Honours `define SP_RAM_ARB_FIXED_PRIO_EN (requester 0 absolute priority) via rr_arbiter.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ-1:0]            REQ_WR,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_BW,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [DATA_WIDTH-1:0]         RSP_DATA,
    output logic [ADDR_WIDTH-1:0]         RAM_A,
    output logic [DATA_WIDTH-1:0]         RAM_DI,
    output logic [DATA_WIDTH-1:0]         RAM_BW,
    output logic                          RAM_CE,
    output logic                          RAM_RDWEN,
    input  logic [DATA_WIDTH-1:0]         RAM_DO
);

    logic [NUM_REQ-1:0] req_gated;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_pend_q, rd_pend_d;
    logic [MAX_REQ-1:0] gnt_ext;
    logic [IDX_W-1:0]   sel;
    logic               sel_wr;

    // Masking requests during reset keeps the grant, RAM drive and pointer quiet.
    assign req_gated = REQ_VALID & {NUM_REQ{~RST}};

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req_gated),
        .advance (|gnt),
        .gnt     (gnt)
    );

    assign REQ_READY = gnt;

    always_comb begin
        gnt_ext              = '0;
        gnt_ext[NUM_REQ-1:0] = gnt;
        sel                  = onehot_to_idx(gnt_ext);
        sel_wr               = |(REQ_WR & gnt);
        RAM_CE               = 1'b0;
        RAM_RDWEN            = RDWEN_RD;
        RAM_A                = '0;
        RAM_DI               = '0;
        RAM_BW               = '0;
        if (|gnt) begin
            RAM_CE    = 1'b1;
            RAM_RDWEN = sel_wr ? RDWEN_WR : RDWEN_RD;
            RAM_A     = ADDR_WIDTH'(REQ_ADDR >> (32'(sel) * ADDR_WIDTH));
            RAM_DI    = DATA_WIDTH'(REQ_WDATA >> (32'(sel) * DATA_WIDTH));
            RAM_BW    = sel_wr ? DATA_WIDTH'(REQ_BW >> (32'(sel) * DATA_WIDTH)) : '0;
        end
    end

    assign rd_pend_d = gnt & ~REQ_WR;

    always_ff @(posedge CLK) begin
        if (RST) rd_pend_q <= '0;
        else     rd_pend_q <= rd_pend_d;
    end

    // A read accepted just before reset must not surface while RST is high.
    assign RSP_VALID = RST ? '0 : rd_pend_q;
    assign RSP_DATA  = (|RSP_VALID) ? RAM_DO : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a behavioural RAM macro and scoreboard.
// With SP_RAM_ARB_FIXED_PRIO_EN defined it runs NUM_REQ=3 and the fixed-priority scenario.
module tb_sp_ram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    localparam int unsigned N = 3;
    localparam int RST_PTR = 1;
`else
    localparam int unsigned N = 2;
    localparam int RST_PTR = 0;
`endif

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    req_valid, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, req_bw;
    logic [N-1:0]    REQ_READY, RSP_VALID;
    logic [DW-1:0]   RSP_DATA, RAM_DI, RAM_BW, RAM_DO;
    logic [AW-1:0]   RAM_A;
    logic            RAM_CE, RAM_RDWEN;

    sp_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (req_valid),
        .REQ_READY (REQ_READY),
        .REQ_WR    (req_wr),
        .REQ_ADDR  (req_addr),
        .REQ_WDATA (req_wdata),
        .REQ_BW    (req_bw),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RAM_A     (RAM_A),
        .RAM_DI    (RAM_DI),
        .RAM_BW    (RAM_BW),
        .RAM_CE    (RAM_CE),
        .RAM_RDWEN (RAM_RDWEN),
        .RAM_DO    (RAM_DO)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port macro driven purely by the DUT's pins.
    logic [DW-1:0] ram_mem [1<<AW];
    logic [DW-1:0] ram_do_q = '0;
    assign RAM_DO = ram_do_q;
    always @(posedge CLK) begin
        if (RAM_CE) begin
            if (RAM_RDWEN) ram_mem[RAM_A] <= (ram_mem[RAM_A] & ~RAM_BW) | (RAM_DI & RAM_BW);
            else           ram_do_q <= ram_mem[RAM_A];
        end
    end

    // Scoreboard state: expected memory, rotation pointer, outstanding read.
    logic [DW-1:0] ref_mem [1<<AW];
    int            ref_ptr = RST_PTR;
    int            pend = -1;
    logic [DW-1:0] pend_data;
    int            exp_g;
    logic [N-1:0]  exp_ready, exp_rsp_valid;
    logic [DW-1:0] exp_rsp_data;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic predict();
        exp_g = -1;
        if (!RST) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
            if (req_valid[0]) exp_g = 0;
            for (int k = 0; k < N - 1; k++) begin
                int c;
                c = 1 + (ref_ptr - 1 + k) % (N - 1);
                if (exp_g < 0 && req_valid[c]) exp_g = c;
            end
`else
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ref_ptr + k) % N;
                if (exp_g < 0 && req_valid[c]) exp_g = c;
            end
`endif
        end
        exp_ready     = (exp_g >= 0) ? N'(1) << exp_g : '0;
        exp_rsp_valid = (!RST && pend >= 0) ? N'(1) << pend : '0;
        exp_rsp_data  = (!RST && pend >= 0) ? pend_data : '0;
    endtask

    task automatic tick();
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        predict();
        @(posedge CLK);
        if (RST) begin
            ref_ptr = RST_PTR;
            pend    = -1;
        end else begin
            pend = -1;
            if (exp_g >= 0) begin
                a = req_addr[exp_g*AW +: AW];
                d = req_wdata[exp_g*DW +: DW];
                m = req_bw[exp_g*DW +: DW];
                if (req_wr[exp_g]) begin
                    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
                end else begin
                    pend      = exp_g;
                    pend_data = ref_mem[a];
                end
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
                if (exp_g != 0) ref_ptr = (exp_g == N - 1) ? 1 : exp_g + 1;
`else
                ref_ptr = (exp_g + 1) % N;
`endif
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_valid[i]          = v;
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_bw[i*DW +: DW]    = m;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_bw    = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_checks += 3;
            if (REQ_READY !== '0) begin
                n_errors++; $display("FAIL reset_ready: got %b want 0", REQ_READY);
            end
            if (RAM_CE !== 1'b0) begin
                n_errors++; $display("FAIL reset_ce: got %b want 0", RAM_CE);
            end
            if (RSP_VALID !== '0 || RSP_DATA !== '0) begin
                n_errors++; $display("FAIL reset_rsp: got %b/%h want 0/0", RSP_VALID, RSP_DATA);
            end
            tick();
        end
        RST = 1'b0;
        @(negedge CLK);
        predict();
        n_checks += 2;
        if (REQ_READY !== exp_ready) begin
            n_errors++; $display("FAIL reset_first_model: got %b want %b", REQ_READY, exp_ready);
        end
        if (REQ_READY !== N'(1)) begin
            n_errors++; $display("FAIL reset_first_grant: got %b want %b", REQ_READY, N'(1));
        end
        tick();
        clear_all();
        tick();
    endtask

    task automatic test_single_read();
        set_req(1, 1'b1, 1'b1, AW'(5), 64'hDEAD_BEEF, '1);
        @(negedge CLK);
        predict();
        n_checks++;
        if (REQ_READY !== exp_ready || RAM_RDWEN !== 1'b1) begin
            n_errors++; $display("FAIL single_wr: got %b/%b want %b/1", REQ_READY, RAM_RDWEN, exp_ready);
        end
        tick();
        set_req(1, 1'b1, 1'b0, AW'(5), '0, '0);
        @(negedge CLK);
        predict();
        n_checks++;
        if (REQ_READY !== exp_ready) begin
            n_errors++; $display("FAIL single_rd_grant: got %b want %b", REQ_READY, exp_ready);
        end
        tick();
        clear_all();
        @(negedge CLK);
        n_checks += 2;
        if (RSP_VALID !== N'(2)) begin
            n_errors++; $display("FAIL single_rsp_valid: got %b want %b", RSP_VALID, N'(2));
        end
        if (RSP_DATA !== 64'hDEAD_BEEF) begin
            n_errors++; $display("FAIL single_rsp_data: got %h want deadbeef", RSP_DATA);
        end
        tick();
    endtask

    task automatic test_bit_mask();
        set_req(0, 1'b1, 1'b1, AW'(60), '1, '1);
        tick();
        set_req(0, 1'b1, 1'b1, AW'(60), '0, 64'hFF);
        tick();
        set_req(0, 1'b1, 1'b0, AW'(60), '1, '1);
        @(negedge CLK);
        n_checks += 2;
        if (RAM_BW !== '0) begin
            n_errors++; $display("FAIL mask_rd_bw: got %h want 0", RAM_BW);
        end
        if (RAM_CE !== 1'b1 || RAM_RDWEN !== 1'b0) begin
            n_errors++; $display("FAIL mask_rd_pins: got ce=%b rdwen=%b want 1/0", RAM_CE, RAM_RDWEN);
        end
        tick();
        clear_all();
        @(negedge CLK);
        n_checks++;
        if (RSP_DATA !== 64'hFFFF_FFFF_FFFF_FF00 || RSP_VALID !== N'(1)) begin
            n_errors++; $display("FAIL mask_data: got %b/%h want %b/ffffffffffffff00",
                                 RSP_VALID, RSP_DATA, N'(1));
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] hold = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                            AW'($urandom_range(0, 15)), {$urandom, $urandom},
                            ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom});
                end
            end
            @(negedge CLK);
            predict();
            n_checks += 4;
            if (REQ_READY !== exp_ready) begin
                n_errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, REQ_READY, exp_ready);
            end
            if (RAM_CE !== (exp_g >= 0)) begin
                n_errors++; $display("FAIL rand_ce c=%0d: got %b want %b", c, RAM_CE, exp_g >= 0);
            end
            if (RSP_VALID !== exp_rsp_valid) begin
                n_errors++; $display("FAIL rand_rsp_valid c=%0d: got %b want %b", c, RSP_VALID, exp_rsp_valid);
            end
            if (RSP_DATA !== exp_rsp_data) begin
                n_errors++; $display("FAIL rand_rsp_data c=%0d: got %h want %h", c, RSP_DATA, exp_rsp_data);
            end
            if (exp_g >= 0) begin
                n_checks += 3;
                if (RAM_A !== req_addr[exp_g*AW +: AW] || RAM_RDWEN !== req_wr[exp_g]) begin
                    n_errors++; $display("FAIL rand_a_rdwen c=%0d: got %h/%b want %h/%b", c, RAM_A,
                                         RAM_RDWEN, req_addr[exp_g*AW +: AW], req_wr[exp_g]);
                end
                if (RAM_BW !== (req_wr[exp_g] ? req_bw[exp_g*DW +: DW] : '0)) begin
                    n_errors++; $display("FAIL rand_bw c=%0d: got %h wr=%b", c, RAM_BW, req_wr[exp_g]);
                end
                if (req_wr[exp_g] && RAM_DI !== req_wdata[exp_g*DW +: DW]) begin
                    n_errors++; $display("FAIL rand_di c=%0d: got %h want %h", c, RAM_DI,
                                         req_wdata[exp_g*DW +: DW]);
                end
            end else begin
                n_checks++;
                if (RAM_A !== '0 || RAM_DI !== '0 || RAM_BW !== '0) begin
                    n_errors++; $display("FAIL rand_idle_pins c=%0d: got %h/%h/%h want 0", c, RAM_A, RAM_DI, RAM_BW);
                end
            end
            hold = req_valid & ~exp_ready;
            tick();
        end
        clear_all();
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] prev = '0;
        set_req(0, 1'b1, 1'b1, AW'(20), 64'h1111_2222_3333_4444, '1);
        tick();
        clear_all();
        set_req(1, 1'b1, 1'b1, AW'(21), 64'h5555_6666_7777_8888, '1);
        tick();
        set_req(0, 1'b1, 1'b0, AW'(20), '0, '0);
        set_req(1, 1'b1, 1'b0, AW'(21), '0, '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            predict();
            n_checks += 4;
            if (REQ_READY !== exp_ready || RAM_CE !== 1'b1) begin
                n_errors++; $display("FAIL cont_grant c=%0d: got %b ce=%b want %b", c, REQ_READY, RAM_CE, exp_ready);
            end
            if (c > 0 && REQ_READY === prev) begin
                n_errors++; $display("FAIL cont_alternate c=%0d: got %b twice", c, REQ_READY);
            end
            if (RSP_VALID !== exp_rsp_valid) begin
                n_errors++; $display("FAIL cont_rsp_valid c=%0d: got %b want %b", c, RSP_VALID, exp_rsp_valid);
            end
            if (RSP_DATA !== exp_rsp_data) begin
                n_errors++; $display("FAIL cont_rsp_data c=%0d: got %h want %h", c, RSP_DATA, exp_rsp_data);
            end
            prev = REQ_READY;
            tick();
        end
        clear_all();
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b0, AW'(5), '0, '0);
        @(negedge CLK);
        n_checks++;
        if (REQ_READY !== N'(1)) begin
            n_errors++; $display("FAIL rmid_grant: got %b want %b", REQ_READY, N'(1));
        end
        tick();
        clear_all();
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== '0 || RSP_DATA !== '0) begin
            n_errors++; $display("FAIL rmid_t1: got %b/%h want 0/0", RSP_VALID, RSP_DATA);
        end
        tick();
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (RSP_VALID !== '0) begin
            n_errors++; $display("FAIL rmid_t2: got %b want 0", RSP_VALID);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        for (int k = 0; k < 4; k++) begin
            set_req(N - 1, 1'b1, 1'b1, AW'(100 + k), {$urandom, $urandom}, '1);
            @(negedge CLK);
            n_checks++;
            if (REQ_READY !== (N'(1) << (N - 1)) || RAM_CE !== 1'b1) begin
                n_errors++; $display("FAIL b2b_grant k=%0d: got %b ce=%b", k, REQ_READY, RAM_CE);
            end
            tick();
        end
        d = {$urandom, $urandom};
        set_req(N - 1, 1'b1, 1'b1, AW'(200), d, '1);
        tick();
        set_req(N - 1, 1'b1, 1'b0, AW'(200), '0, '0);
        tick();
        clear_all();
        @(negedge CLK);
        n_checks++;
        if (RSP_DATA !== d || RSP_VALID !== (N'(1) << (N - 1))) begin
            n_errors++; $display("FAIL b2b_raw: got %b/%h want %h", RSP_VALID, RSP_DATA, d);
        end
        tick();
    endtask

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [N-1:0] prev = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(20 + i), '0, '0);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            predict();
            n_checks += 2;
            if (REQ_READY !== 3'b001) begin
                n_errors++; $display("FAIL fixed_prio0 c=%0d: got %b want 001", c, REQ_READY);
            end
            if (RSP_DATA !== exp_rsp_data) begin
                n_errors++; $display("FAIL fixed_data c=%0d: got %h want %h", c, RSP_DATA, exp_rsp_data);
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            predict();
            n_checks += 2;
            if (REQ_READY !== exp_ready || REQ_READY[0] !== 1'b0) begin
                n_errors++; $display("FAIL fixed_rr c=%0d: got %b want %b", c, REQ_READY, exp_ready);
            end
            if (c > 0 && REQ_READY === prev) begin
                n_errors++; $display("FAIL fixed_alternate c=%0d: got %b twice", c, REQ_READY);
            end
            prev = REQ_READY;
            tick();
        end
        clear_all();
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        clear_all();
        test_reset();
        test_single_read();
        test_bit_mask();
        test_random();
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
